ppb_host_phy: RTL and testbench

- Host-side (initiator) physical layer of the PMOD probe bus (PPB); it is the far end of the on-target PPB device PHY.
- Generates pmod_bus_clk, pmod_bus_control, pmod_bus_poti and pmod_rst, and captures pmod_bus_pito.
- Each frame reads the target project ID, shifts device-input blocks out, and shifts device-output blocks in.
- Sits on the bench/host FPGA between the debug controller and the PMOD header.

---
 rtl/ppb_host_phy.sv | 144 ++++++++++++++
 tb/tb_ppb_host_phy.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ppb_host_phy.sv
// ppb_host_phy: PPB initiator PHY framing ID/tx/rx beats; define PPB_HOST_CONT_EN for back-to-back frames via cont
module ppb_host_phy #(
  parameter int INPUT_BLOCKS = 20,
  parameter int OUTPUT_BLOCKS = 40,
  parameter int CLK_DIV = 8,
  parameter logic [22:0] EXPECTED_ID = 23'h31c748
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic link_rst,
`ifdef PPB_HOST_CONT_EN
  input  logic cont,
`endif
  input  logic [3*INPUT_BLOCKS-1:0] tx_data,
  output logic busy,
  output logic done,
  output logic [3*OUTPUT_BLOCKS-1:0] rx_data,
  output logic [22:0] rx_id,
  output logic id_err,
  output logic pmod_rst,
  output logic pmod_bus_clk,
  output logic pmod_bus_control,
  output logic [2:0] pmod_bus_poti,
  input  logic [2:0] pmod_bus_pito
);
  localparam int NB = 8 + (INPUT_BLOCKS > OUTPUT_BLOCKS ? INPUT_BLOCKS : OUTPUT_BLOCKS);
  localparam int CW = $clog2(8*CLK_DIV);
  localparam int BW = $clog2(NB);
  typedef enum logic [2:0] {IDLE, RST, HDR, DATA, TAIL} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] beat;
  logic [2:0] s1, s2;
  logic [3*INPUT_BLOCKS-1:0] tx_sh;
  logic [3*OUTPUT_BLOCKS-1:0] rx_sh;
  logic [22:0] id_sh;
  logic half_end, beat_end, last_beat, go_on;
  assign half_end = cnt == CW'(CLK_DIV-1);
  assign beat_end = cnt == CW'(2*CLK_DIV-1);
  assign last_beat = beat == BW'(NB-1);
`ifdef PPB_HOST_CONT_EN
  assign go_on = cont;
`else
  assign go_on = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) {s2, s1} <= '0;
    else begin
      s1 <= pmod_bus_pito;
      s2 <= s1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      beat <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      id_sh <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rx_data <= '0;
      rx_id <= '0;
      id_err <= 1'b0;
      pmod_rst <= 1'b0;
      pmod_bus_clk <= 1'b0;
      pmod_bus_control <= 1'b0;
      pmod_bus_poti <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          beat <= '0;
          if (link_rst) begin
            state <= RST;
            pmod_rst <= 1'b1;
            busy <= 1'b1;
          end else if (start) begin
            state <= HDR;
            busy <= 1'b1;
            pmod_bus_control <= 1'b1;
            pmod_bus_poti <= '0;
            tx_sh <= tx_data;
          end
        end
        RST: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(8*CLK_DIV-1)) begin
            state <= IDLE;
            cnt <= '0;
            pmod_rst <= 1'b0;
            busy <= 1'b0;
          end
        end
        HDR, DATA: begin
          cnt <= beat_end ? '0 : cnt + 1'b1;
          if (half_end) pmod_bus_clk <= 1'b1;
          if (beat_end) begin
            pmod_bus_clk <= 1'b0;
            beat <= beat + 1'b1;
            // id bit 23 arrives on s2[2] of header beat 7 and is dropped
            if (state == HDR) begin
              if (beat == BW'(7)) id_sh[22:21] <= s2[1:0];
              else id_sh[20:0] <= {s2, id_sh[20:3]};
            end else if (int'(beat) < 8 + OUTPUT_BLOCKS)
              rx_sh <= {s2, rx_sh[3*OUTPUT_BLOCKS-1:3]};
            if (last_beat) begin
              state <= TAIL;
              beat <= '0;
              pmod_bus_control <= 1'b0;
              pmod_bus_poti <= '0;
            end else begin
              if (beat == BW'(7)) state <= DATA;
              if (beat >= BW'(7)) begin
                pmod_bus_poti <= tx_sh[2:0];
                tx_sh <= tx_sh >> 3;
              end
            end
          end
        end
        TAIL: begin
          cnt <= cnt + 1'b1;
          if (half_end) begin
            cnt <= '0;
            done <= 1'b1;
            rx_data <= rx_sh;
            rx_id <= id_sh;
            id_err <= id_sh != EXPECTED_ID;
            if (go_on) begin
              state <= HDR;
              pmod_bus_control <= 1'b1;
              tx_sh <= tx_data;
            end else begin
              state <= IDLE;
              busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ppb_host_phy.sv
// tb_ppb_host_phy: randomized frames against a beat-level target model with a done-driven scoreboard
module tb_ppb_host_phy;
  localparam int IB = 2, OB = 3, CD = 4, NB = 11, FL = 1 + 2*CD*NB + CD;
  localparam logic [22:0] EID = 23'h31c748;
  logic clk = 0, rst = 1, start = 0, link_rst = 0;
  logic [3*IB-1:0] tx_data = '0;
  logic busy, done, id_err, pmod_rst, pmod_bus_clk, pmod_bus_control;
  logic [3*OB-1:0] rx_data;
  logic [22:0] rx_id;
  logic [2:0] pmod_bus_poti;
  logic [2:0] pito = '0;
`ifdef PPB_HOST_CONT_EN
  logic cont = 1'b0;
`endif
  always #5 clk = ~clk;
  ppb_host_phy #(.INPUT_BLOCKS(IB), .OUTPUT_BLOCKS(OB), .CLK_DIV(CD), .EXPECTED_ID(EID)) dut (
    .clk(clk), .rst(rst), .start(start), .link_rst(link_rst),
`ifdef PPB_HOST_CONT_EN
    .cont(cont),
`endif
    .tx_data(tx_data), .busy(busy), .done(done), .rx_data(rx_data), .rx_id(rx_id),
    .id_err(id_err), .pmod_rst(pmod_rst), .pmod_bus_clk(pmod_bus_clk),
    .pmod_bus_control(pmod_bus_control), .pmod_bus_poti(pmod_bus_poti), .pmod_bus_pito(pito)
  );
  typedef struct {
    logic [22:0] id;
    logic err;
    logic [3*OB-1:0] rx;
    logic [3*NB-1:0] poti;
    int t0;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  int vectors = 0, errs = 0, cyc = 0, dones = 0, tbeat = 0, run = 0;
  logic [2:0] blk [NB];
  logic [3*NB-1:0] seen_poti = '0;
  logic bclk_q = 0, ctl_q = 0, done_q = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (pmod_bus_control && !ctl_q) begin
      tbeat = 0;
      run = 1;
      pito = blk[0];
      seen_poti = '0;
    end else if (pmod_bus_control) begin
      if (pmod_bus_clk != bclk_q) begin
        check("phase_len", run, CD);
        run = 1;
        if (pmod_bus_clk) begin
          if (tbeat < NB) seen_poti[3*tbeat +: 3] = pmod_bus_poti;
          tbeat++;
        end else if (tbeat < NB) pito = blk[tbeat];
      end else run++;
    end
    bclk_q = pmod_bus_clk;
    ctl_q = pmod_bus_control;
  end
  always @(negedge clk) begin
    if (done) begin
      dones++;
      check("done_width", done_q, 0);
      if (sbq.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL unexpected_done: got done with empty queue want none (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("rx_id", rx_id, e.id);
        check("id_err", id_err, e.err);
        check("rx_data", rx_data, e.rx);
        check("poti_seq", seen_poti, e.poti);
        check("frame_len", cyc - e.t0, FL);
        check("busy_at_done", busy, 0);
      end
    end
    done_q = done;
  end
  task automatic run_frame(input logic [23:0] id24, input logic [3*IB-1:0] tx,
                           input logic [3*(NB-8)-1:0] d, input bit poke);
    exp_t x;
    int n;
    for (int k = 0; k < 8; k++) blk[k] = id24[3*k +: 3];
    for (int j = 0; j < NB-8; j++) blk[8+j] = d[3*j +: 3];
    x.id = id24[22:0];
    x.err = id24[22:0] != EID;
    x.rx = '0;
    for (int j = 0; j < OB; j++) x.rx[3*j +: 3] = (j < NB-8) ? d[3*j +: 3] : 3'd0;
    x.poti = '0;
    for (int b = 8; b < NB; b++) if (b - 8 < IB) x.poti[3*b +: 3] = tx[3*(b-8) +: 3];
    @(negedge clk);
    tx_data = tx;
    start = 1;
    x.t0 = cyc;
    sbq.push_back(x);
    @(negedge clk);
    start = 0;
    tx_data = 6'($urandom);
    n = dones;
    for (int i = 0; i < 3*FL && dones == n; i++) begin
      @(negedge clk);
      start = poke && (i == 40);
      link_rst = poke && (i == 60);
    end
    start = 0;
    link_rst = 0;
    if (dones == n) begin
      vectors++;
      errs++;
      $display("FAIL frame_timeout: got no done want done within %0d cycles", 3*FL);
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    int n, pr, bz, bad;
    logic [22:0] id;
    for (int k = 0; k < NB; k++) blk[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_id", rx_id, 0);
    check("rst_id_err", id_err, 0);
    check("rst_pmod_rst", pmod_rst, 0);
    check("rst_bus_clk", pmod_bus_clk, 0);
    check("rst_control", pmod_bus_control, 0);
    check("rst_poti", pmod_bus_poti, 0);
    rst = 0;
    run_frame({1'b0, EID}, 6'b101_011, 9'b100_010_111, 0);
    run_frame({1'b1, 23'h000001}, 6'($urandom), 9'($urandom), 0);
    run_frame({1'b0, EID}, 6'($urandom), 9'($urandom), 0);
    for (int f = 0; f < 20; f++) begin
      id = ($urandom_range(0, 3) == 0) ? 23'($urandom) : EID;
      run_frame({1'($urandom), id}, 6'($urandom), 9'($urandom), 1'($urandom));
    end
    @(negedge clk);
    link_rst = 1;
    start = 1;
    @(negedge clk);
    link_rst = 0;
    start = 0;
    n = dones;
    pr = 0;
    bz = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (pmod_rst) pr++;
      if (busy) bz++;
      if (pmod_bus_clk || pmod_bus_control) bad++;
      start = (i == 10);
      @(negedge clk);
    end
    start = 0;
    check("link_rst_len", pr, 8*CD);
    check("link_busy_len", bz, 8*CD);
    check("link_bus_quiet", bad, 0);
    check("link_no_done", dones - n, 0);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (20) @(negedge clk);
    check("mid_control_active", pmod_bus_control, 1);
    rst = 1;
    #1;
    check("mid_rst_bus_clk", pmod_bus_clk, 0);
    check("mid_rst_control", pmod_bus_control, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pmod_rst", pmod_rst, 0);
    check("mid_rst_rx_id", rx_id, 0);
    check("mid_rst_poti", pmod_bus_poti, 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    run_frame({1'b0, EID}, 6'($urandom), 9'($urandom), 0);
    check("queue_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
